// File: rtl/alu_issue_queue.sv
// -----------------------------------------------------------------------------
// alu_issue_queue
//
// Issue stage in front of an external 8-bit combinational ALU. Operation
// requests (A, B, select) arrive over a valid/ready handshake and are buffered
// in a DEPTH-entry FIFO. The FIFO head drives the ALU inputs. The ALU result
// comes back combinationally and is captured into a registered output stage,
// which has its own valid/ready handshake. A divide request with B == 0 is
// flagged on out_divz; its result is passed through unchanged.
//
// Parameters:
//   DEPTH  - FIFO entries (power of 2, >= 2)
//   DATA_W - operand / result width
//   SEL_W  - ALU select width
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - request handshake (in_ready = count < DEPTH, 0 in rst)
//   in_a, in_b, in_sel  - request operands and opcode
//   alu_a, alu_b, alu_sel - FIFO head to the ALU (all zero when empty)
//   alu_result          - combinational ALU result for the current head
//   out_valid/out_ready - result handshake
//   out_result, out_sel - registered result and the opcode that produced it
//   out_divz            - result came from a divide (sel 0011) with B == 0
//   count               - FIFO occupancy, 0..DEPTH
//
// Optional feature (macro ALU_ISSUE_STATS_EN):
//   op_count   - 16-bit count of result handshakes, wraps, cleared by rst
//   divz_count - 8-bit count of handshakes that carried out_divz, wraps
// -----------------------------------------------------------------------------
module alu_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [SEL_W-1:0]         alu_sel,
  input  logic [DATA_W-1:0]        alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_divz,
  output logic [$clog2(DEPTH):0]   count
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]              op_count,
  output logic [7:0]               divz_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [SEL_W-1:0]  SEL_DIV   = SEL_W'(3);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

  // FIFO storage (not cleared by reset; only the pointers define validity)
  logic [DATA_W-1:0] r_mem_a   [DEPTH];
  logic [DATA_W-1:0] r_mem_b   [DEPTH];
  logic [SEL_W-1:0]  r_mem_sel [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_result;
  logic [SEL_W-1:0]  r_out_sel;
  logic              r_out_divz;

  logic              w_empty;
  logic              w_in_ready;
  logic              w_push;
  logic              w_cap;
  logic              w_hs;
  logic [DATA_W-1:0] w_head_a;
  logic [DATA_W-1:0] w_head_b;
  logic [SEL_W-1:0]  w_head_sel;
  logic              w_head_divz;

  // Divide-by-zero detection for one FIFO entry.
  function automatic logic is_divz(input logic [SEL_W-1:0] sel,
                                   input logic [DATA_W-1:0] b);
    return (sel == SEL_DIV) && (b == {DATA_W{1'b0}});
  endfunction

  // Handshake and capture qualifiers.
  always_comb begin
    w_empty    = (r_count == {CNT_W{1'b0}});
    // Full is judged on the registered count only: no push-at-full even
    // when the head is popped in the same cycle.
    w_in_ready = !rst && (r_count < CNT_FULL);
    w_push     = in_valid && w_in_ready;
    w_cap      = !w_empty && (!r_out_valid || out_ready);
    w_hs       = r_out_valid && out_ready;
  end

  // Head of the FIFO presented to the ALU; zeroes while empty.
  always_comb begin
    if (w_empty) begin
      w_head_a   = {DATA_W{1'b0}};
      w_head_b   = {DATA_W{1'b0}};
      w_head_sel = {SEL_W{1'b0}};
    end else begin
      w_head_a   = r_mem_a[r_rd_ptr];
      w_head_b   = r_mem_b[r_rd_ptr];
      w_head_sel = r_mem_sel[r_rd_ptr];
    end
    w_head_divz = !w_empty && is_divz(w_head_sel, w_head_b);
  end

  // FIFO entry write on an accepted request.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]   <= in_a;
      r_mem_b[r_wr_ptr]   <= in_b;
      r_mem_sel[r_wr_ptr] <= in_sel;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_cap) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_cap})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output register: captures the ALU result of the head, holds under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= {DATA_W{1'b0}};
      r_out_sel    <= {SEL_W{1'b0}};
      r_out_divz   <= 1'b0;
    end else if (w_cap) begin
      r_out_valid  <= 1'b1;
      r_out_result <= alu_result;
      r_out_sel    <= w_head_sel;
      r_out_divz   <= w_head_divz;
    end else if (w_hs) begin
      r_out_valid  <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] r_op_count;
  logic [7:0]  r_divz_count;

  // Handshake statistics; both counters wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count   <= 16'd0;
      r_divz_count <= 8'd0;
    end else if (w_hs) begin
      r_op_count <= r_op_count + 16'd1;
      if (r_out_divz) begin
        r_divz_count <= r_divz_count + 8'd1;
      end
    end
  end

  assign op_count   = r_op_count;
  assign divz_count = r_divz_count;
`endif

  assign in_ready   = w_in_ready;
  assign alu_a      = w_head_a;
  assign alu_b      = w_head_b;
  assign alu_sel    = w_head_sel;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_sel    = r_out_sel;
  assign out_divz   = r_out_divz;
  assign count      = r_count;

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
Upstream issue stage for the 8-bit combinational ALU. It accepts operation requests (A, B, select) over a valid/ready handshake and buffers them in a small FIFO. The FIFO head drives the ALU operand/select inputs; the ALU result is captured into a registered output stage with its own valid/ready handshake. It decouples the request producer from the result consumer and adds divide-by-zero flagging.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
DATA_W, 8, operand/result width (matches ALU)
SEL_W, 4, ALU select width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  queue can accept (count < DEPTH)
in_a  in  DATA_W  operand A
in_b  in  DATA_W  operand B
in_sel  in  SEL_W  ALU opcode (0000 add … 0011 div … 1111 equal)
alu_a  out  DATA_W  to ALU A (FIFO head A, 0 when empty)
alu_b  out  DATA_W  to ALU B (FIFO head B, 0 when empty)
alu_sel  out  SEL_W  to ALU select (FIFO head sel, 0 when empty)
alu_result  in  DATA_W  from ALU output (combinational on alu_a/b/sel)
out_valid  out  1  result register holds valid data
out_ready  in  1  consumer accepts result
out_result  out  DATA_W  registered ALU result
out_sel  out  SEL_W  opcode that produced out_result
out_divz  out  1  result came from sel=0011 with B=0
count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=1 at edge): rd/wr pointers 0, count 0, out_valid 0, out_result 0, out_sel 0, out_divz 0. FIFO contents are not cleared. Reset mid-operation discards all queued and held operations. in_ready=0 while rst=1.
- Push: in_valid && in_ready at edge writes {in_a,in_b,in_sel} at wr_ptr; wr_ptr wraps modulo DEPTH.
- in_ready = (count < DEPTH). There is no push-at-full even if a pop occurs the same cycle.
- Head: while count>0, alu_a/alu_b/alu_sel present the entry at rd_ptr. The ALU is combinational, so alu_result is valid in the same cycle.
- Capture condition cap = (count>0) && (!out_valid || out_ready). On cap: out_result<=alu_result, out_sel<=head sel, out_divz<=(head sel==4'b0011 && head B==0), out_valid<=1, pop head (rd_ptr wraps).
- out_valid && out_ready && !cap: out_valid<=0.
- Output register holds its value stable while out_valid && !out_ready.
- Simultaneous push and pop: count unchanged; a push into an empty FIFO is not visible at the head until the next cycle.
- Latency: accept at edge N -> head valid after N -> captured at edge N+1 -> out_valid high after edge N+1 (1 cycle bubble-free when out_ready=1). Throughput: 1 op/cycle sustained.
- Total in-flight capacity is DEPTH+1 (FIFO plus output register).
- Divide-by-zero: the result is passed through unchanged from the ALU; only out_divz is raised.
- count: 0..DEPTH. The FIFO never overflows or underflows; pops occur only when count>0.

Optional Feature:
ALU_ISSUE_STATS_EN. When defined, adds output op_count (16 bits) and divz_count (8 bits).
- op_count increments on every out_valid&&out_ready handshake.
- divz_count increments on those handshakes where out_divz=1.
- Both counters wrap on overflow and clear on rst.
When not defined, neither port nor its logic exists.

Test Plan:
1. Single op, out_ready=1: push A=125,B=5,sel=0000 -> alu_a=125 the next cycle; out_valid with out_result=130, out_sel=0000, out_divz=0 one edge later.
2. Back-to-back stream with out_ready=1: push add, sub, and (125/5) each cycle -> results 130, 120, 5 on consecutive cycles, no bubbles.
3. Backpressure: out_ready=0, push 6 ops -> in_ready low after 5 accepted (count=4 + held result); out_result stays stable. Release out_ready -> all 5 results delivered in order.
4. Divide by zero: push A=10,B=0,sel=0011 -> out_divz=1, out_sel=0011. A following 125/5 op gives out_divz=0.
5. Reset mid-operation: 3 queued plus 1 held, assert rst one cycle -> count=0, out_valid=0, in_ready=1. A new push of 8+8 yields 16 with no stale results.
6. Pointer wrap (DEPTH=4): 10 ops with push/pop alternating in occupancy 1..4 -> all results in order, count never exceeds 4. With ALU_ISSUE_STATS_EN defined, op_count=10 at the end.
